regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order writeback stage (primary, no backpressure);
  - the long-latency unit (mul/div/load return path, secondary, valid/ready).
- Secondary results wait in a small FIFO and drain into free write-port cycles.
- Exposes a pending-write mask so decode can stall on hazards.
- Issues a one-cycle writeback stall when a queued result has waited too long.

Parameters:
- DEPTH, 4, secondary FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before a forced drain (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  writeback result valid; ignored in any cycle where wb_stall=1
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- wb_stall  out  1  registered; writeback must hold its result this cycle
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept; driven only from state
- lu_rd  in  5  long-latency destination
- lu_data  in  32  long-latency data
- rf_we  out  1  registered register-file write enable
- rf_rd  out  5  registered register-file write address
- rf_wdata  out  32  registered register-file write data
- pending_mask  out  32  bit i=1 when a live FIFO entry targets xi; driven only from state

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; wait counter 0.
  - rf_we=0, rf_rd=0, rf_wdata=0, wb_stall=0, pending_mask=0.
  - lu_ready=0 while rst_n=0, 1 from the first cycle after release.
  - Reset mid-drain discards all queued entries with no write.
- Primary accept: wb_valid=1 and wb_stall=0.
  - If wb_rd!=0, cycle N+1 gives rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data.
- Secondary accept: lu_valid=1 and lu_ready=1 (lu_ready = !full).
  - If lu_rd!=0, the entry is enqueued with a live bit. Full with lu_valid=1 means hold and no accept.
- rd==0 from either source: accepted (handshake completes), never enqueued, never written.
- Write-port priority per cycle:
  - A non-stalled primary accept with wb_rd!=0 wins.
  - Otherwise the FIFO head is popped when non-empty. If the head is live, the next cycle gives rf_we=1 with the head's rd and data. A dead head pops with rf_we=0.
  - rf_we=0 when neither applies.
- WAW squash: a primary accept with wb_rd=X clears the live bit of every FIFO entry with rd=X, and the matching pending_mask bit clears next cycle.
  - A same-cycle secondary accept with lu_rd=X is accepted and discarded, since the primary is younger.
- Simultaneous pop and push: both occur. Count is unchanged, so lu_ready stays as it was.
- pending_mask: OR over live entries, updated the cycle after any push, pop or squash.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; clears on pop or when the FIFO is empty.
  - On reaching STARVE_LIMIT-1, wb_stall=1 for exactly the next cycle. In that cycle wb_valid is ignored and the head pops.
  - wb_stall never asserts on two consecutive cycles.
- Latency:
  - Primary to register file: 1 cycle.
  - Secondary with an idle port: 2 cycles (enqueue, then pop).
- Pointers are log2(DEPTH) bits plus one wrap bit; full and empty are derived from the wrap-bit compare.

Decomposition:
- Shared package regfile_pkg:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32;
  - struct rf_wr_req_t {rd, data};
  - a FIFO entry struct adding the live bit.
- One sub-module, regfile_wr_fifo: circular buffer holding rf_wr_req_t plus live bits.
  - Ports for push/pop/full/empty.
  - A squash-by-rd input.
  - A live-entry mask output.
- The arbiter top holds priority, the starvation counter and the output registers.

Test Plan:
- Primary only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF in cycle N -> cycle N+1 shows rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF. wb_rd=0 gives rf_we=0.
- Idle-port drain: lu push rd=7, data=0x1234 with no wb -> pending_mask[7]=1 the next cycle, rf_we with rd=7 two cycles after the push, then pending_mask=0.
- Full/backpressure with continuous wb traffic:
  - 4 lu pushes (rd=1..4) -> lu_ready=0 after the 4th, and a 5th lu_valid is held.
  - wb_stall pulses once, 8 cycles after the first push; rd=1 is written in that cycle+1 and lu_ready returns to 1.
- WAW squash: push lu rd=9, then wb rd=9 data=0xAAAA before the drain -> pending_mask[9] clears, only 0xAAAA is written to x9, and the dead entry pops with rf_we=0.
- Same-cycle collision: wb rd=3 and lu rd=3 in the same cycle -> only wb_data is written, the FIFO stays empty and the lu handshake completes.
- Reset mid-operation: 3 entries queued, rst_n low for 1 cycle -> immediately rf_we=0, pending_mask=0, wb_stall=0. After release lu_ready=1 and no stale writes occur.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write arbiter.
// Write request and FIFO entry bundles.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;

  typedef struct packed {
    logic       live;
    rf_wr_req_t req;
  } rf_fifo_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(
    input logic [REG_ADDR_W-1:0] rd
  );
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regfile_wr_fifo.sv
// Circular buffer of pending long-latency writes.
// Entries carry a live bit cleared by a younger writeback.
import regfile_pkg::*;

module regfile_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  rf_wr_req_t            push_req,
  input  logic                  pop,
  output rf_fifo_entry_t        head,
  output logic                  full,
  output logic                  empty,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output logic [NUM_REGS-1:0]   live_mask
);
  localparam int AW = $clog2(DEPTH);

  rf_fifo_entry_t mem [DEPTH];
  logic [AW:0]    wp;
  logic [AW:0]    rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  // Slots outside the occupied range always hold live=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash_en && mem[i].req.rd == squash_rd)
          mem[i].live <= 1'b0;
      if (pop) begin
        mem[rp[AW-1:0]].live <= 1'b0;
        rp <= rp + 1'b1;
      end
      if (push) begin
        mem[wp[AW-1:0]] <= '{live: 1'b1, req: push_req};
        wp <= wp + 1'b1;
      end
    end
  end

  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].live)
        live_mask = live_mask | rd_onehot(mem[i].req.rd);
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between
// the in-order writeback and the long-latency return path.
import regfile_pkg::*;

module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_stall,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   pending_mask
);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;

  logic           rdy_q;
  logic           full;
  logic           empty;
  rf_fifo_entry_t head;
  logic           wb_acc;
  logic           wb_wr;
  logic           lu_acc;
  logic           push;
  logic           pop;
  logic [CW-1:0]  wait_cnt;
  logic [CW-1:0]  wait_nxt;

  assign lu_ready = rdy_q & ~full;
  assign wb_acc   = wb_valid & ~wb_stall;
  assign wb_wr    = wb_acc && (wb_rd != '0);
  assign lu_acc   = lu_valid & lu_ready;
  // Same-rd collision: the writeback is younger, drop the lu result
  assign push     = lu_acc && (lu_rd != '0) &&
                    !(wb_acc && wb_rd == lu_rd);
  assign pop      = ~empty & ~wb_wr;
  assign wait_nxt = (empty || pop) ? '0 : wait_cnt + CW'(1);

  regfile_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_req  ('{rd: lu_rd, data: lu_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .squash_en (wb_wr),
    .squash_rd (wb_rd),
    .live_mask (pending_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      wait_cnt <= '0;
      wb_stall <= 1'b0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rdy_q    <= 1'b1;
      wait_cnt <= wait_nxt;
      wb_stall <= (wait_nxt == CW'(STARVE_LIMIT - 1));
      rf_we    <= wb_wr | (pop & head.live);
      if (wb_wr) begin
        rf_rd    <= wb_rd;
        rf_wdata <= wb_data;
      end else if (pop && head.live) begin
        rf_rd    <= head.req.rd;
        rf_wdata <= head.req.data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter
// against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_stall     (wb_stall),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          live;
  } m_t;

  m_t          q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_stall;
  bit          m_ren;
  int          m_wait;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit exp_ready();
    return m_ren && q.size() < DEPTH;
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we    = 0;
    m_rd    = '0;
    m_data  = '0;
    m_stall = 0;
    m_ren   = 0;
    m_wait  = 0;
  endtask

  task automatic check_all();
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_rd", 64'(rf_rd), 64'(m_rd));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
    chk("wb_stall", 64'(wb_stall), 64'(m_stall));
    chk("lu_ready", 64'(lu_ready), 64'(exp_ready()));
    chk("pending_mask", 64'(pending_mask), 64'(exp_mask()));
  endtask

  task automatic step(input bit wv, input logic [4:0] wr,
                      input logic [31:0] wd, input bit lv,
                      input logic [4:0] lr, input logic [31:0] ld);
    bit wacc, ww, lacc, was_empty, popped;
    m_t h;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    wacc      = wv && !m_stall;
    ww        = wacc && wr != 0;
    lacc      = lv && exp_ready();
    was_empty = (q.size() == 0);
    popped    = 0;
    if (ww) foreach (q[i]) if (q[i].rd == wr) q[i].live = 0;
    if (!ww && !was_empty) begin
      h = q.pop_front();
      popped = 1;
    end
    if (lacc && lr != 0 && !(wacc && wr == lr))
      q.push_back('{rd: lr, d: ld, live: 1'b1});
    if (ww) begin
      m_we = 1; m_rd = wr; m_data = wd;
    end else if (popped && h.live) begin
      m_we = 1; m_rd = h.rd; m_data = h.d;
    end else begin
      m_we = 0;
    end
    m_wait  = (was_empty || popped) ? 0 : m_wait + 1;
    m_stall = (m_wait == STARVE - 1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_stall", 64'(wb_stall), 64'd0);
    chk("rst_ready", 64'(lu_ready), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ren = 1;
    chk("ready_after_rst", 64'(lu_ready), 64'd1);

    // primary only
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("p_we", 64'(rf_we), 64'd1);
    chk("p_rd", 64'(rf_rd), 64'd5);
    chk("p_data", 64'(rf_wdata), 64'hDEADBEEF);
    step(1, 0, 32'h1111, 0, 0, 0);
    chk("p_rd0_we", 64'(rf_we), 64'd0);

    // idle-port drain
    step(0, 0, 0, 1, 7, 32'h1234);
    chk("d_mask", 64'(pending_mask), 64'h80);
    chk("d_we0", 64'(rf_we), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("d_we", 64'(rf_we), 64'd1);
    chk("d_rd", 64'(rf_rd), 64'd7);
    chk("d_data", 64'(rf_wdata), 64'h1234);
    chk("d_mask0", 64'(pending_mask), 64'd0);

    // full + starvation with continuous writeback
    for (int i = 0; i < 9; i++) begin
      step(1, 20, 32'(i), 1, (i < 4) ? 5'(i + 1) : 5'd5,
           32'h100 + 32'(i));
      if (i == 3) chk("f_ready0", 64'(lu_ready), 64'd0);
      if (i == 6) chk("f_nostall", 64'(wb_stall), 64'd0);
      if (i == 7) chk("f_stall", 64'(wb_stall), 64'd1);
      if (i == 8) begin
        chk("f_we", 64'(rf_we), 64'd1);
        chk("f_rd", 64'(rf_rd), 64'd1);
        chk("f_ready1", 64'(lu_ready), 64'd1);
        chk("f_stall_off", 64'(wb_stall), 64'd0);
      end
    end
    idle(8);

    // WAW squash
    step(0, 0, 0, 1, 9, 32'h5555);
    chk("w_mask", 64'(pending_mask), 64'h200);
    step(1, 9, 32'hAAAA, 0, 0, 0);
    chk("w_we", 64'(rf_we), 64'd1);
    chk("w_data", 64'(rf_wdata), 64'hAAAA);
    chk("w_mask0", 64'(pending_mask), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("w_dead_pop", 64'(rf_we), 64'd0);
    idle(2);

    // same-cycle collision
    step(1, 3, 32'hC0DE, 1, 3, 32'hBAD0);
    chk("c_data", 64'(rf_wdata), 64'hC0DE);
    chk("c_mask", 64'(pending_mask), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_nowrite", 64'(rf_we), 64'd0);

    // reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1, 20, 32'(i), 1, 5'(11 + i), 32'h300 + 32'(i));
    step(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_we", 64'(rf_we), 64'd0);
    chk("r_mask", 64'(pending_mask), 64'd0);
    chk("r_stall", 64'(wb_stall), 64'd0);
    chk("r_ready", 64'(lu_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ren = 1;
    chk("r_ready1", 64'(lu_ready), 64'd1);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
